prefetch_queue: RTL

PREFETCH_QUEUE -- requirements
Module: prefetch_queue

---
 rtl/prefetch_queue.sv | 128 ++++++++++++
 1 files changed

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: circular buffer between fetch and decode, first-word-fall-through head.
// Latency: a word pushed into an empty queue is visible one edge later; PFQ_BYPASS_EN adds a zero-latency empty-queue path.
// Backpressure: push_ready drops when full or flushing; pop of an invalid head is ignored.
module prefetch_queue #(
    parameter int DW    = 32,
    parameter int AW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [DW-1:0]            push_data,
    input  logic [AW-1:0]            push_addr,
    input  logic                     pop,
    output logic [DW-1:0]            ir,
    output logic [AW-1:0]            ir_addr,
    output logic                     ir_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head_q;
    entry_t        head_n;
    entry_t        wr_entry;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr_n;
    logic [PW-1:0] wr_ptr_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          empty;
    logic          full;
    logic          bypass;
    logic          bypass_take;
    logic          do_push;
    logic          do_pop;
    logic          do_pop_mem;
    logic          head_ld;

    assign empty      = (cnt == '0);
    assign full       = (cnt == FULL_CNT);
    assign push_ready = !full && !flush;
    assign count      = cnt;

`ifdef PFQ_BYPASS_EN
    assign bypass = empty && !flush;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        ir_valid = !empty;
        ir       = head_q.dat;
        ir_addr  = head_q.addr;
        if (bypass) begin
            ir_valid = push_valid;
            ir       = push_data;
            ir_addr  = push_addr;
        end
    end

    // A bypassed word that is popped in the same cycle never touches storage.
    assign do_pop      = pop && ir_valid && !flush;
    assign bypass_take = bypass && push_valid && pop;
    assign do_push     = push_valid && push_ready && !bypass_take;
    assign do_pop_mem  = do_pop && !empty;

    always_comb begin
        rd_ptr_n = rd_ptr;
        wr_ptr_n = wr_ptr;
        cnt_n    = cnt;
        if (flush) begin
            rd_ptr_n = '0;
            wr_ptr_n = '0;
            cnt_n    = '0;
        end else begin
            rd_ptr_n = rd_ptr + PW'(do_pop_mem);
            wr_ptr_n = wr_ptr + PW'(do_push);
            cnt_n    = cnt + CW'(do_push) - CW'(do_pop_mem);
        end
    end

    // The head register tracks the entry the read pointer will address next edge;
    // it only reloads when that entry is valid so ir holds its last value otherwise.
    always_comb begin
        wr_entry.addr = push_addr;
        wr_entry.dat  = push_data;
        head_n        = mem[rd_ptr_n];
        if (do_push && (wr_ptr == rd_ptr_n)) begin
            head_n = wr_entry;
        end
        head_ld = !flush && (cnt_n != '0);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            head_q <= '0;
        end else begin
            rd_ptr <= rd_ptr_n;
            wr_ptr <= wr_ptr_n;
            cnt    <= cnt_n;
            if (head_ld) begin
                head_q <= head_n;
            end
        end
    end

endmodule
